// File: rtl/rtc_bus_responder.sv
// V3023-style multiplexed RTC bus responder.
// BCD time base, control register and 12-byte scratch RAM.
module rtc_bus_responder #(
  parameter int unsigned TICK_DIV = 100_000_000,
  parameter int unsigned READ_LAT = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       AD,
  input  logic       CS,
  input  logic       RD,
  input  logic       WR,
  input  logic [7:0] data_in,
  output logic [7:0] data_out,
  output logic       data_oe,
  output logic       tick,
  output logic       bus_err
);

  localparam int unsigned PW = $clog2(TICK_DIV);
  localparam logic [PW-1:0] TOP = PW'(TICK_DIV - 1);
  localparam logic [2:0] LAT = 3'(READ_LAT);

  typedef enum logic [1:0] {
    IDLE,
    SEL,
    READ,
    ERR
  } state_t;

  function automatic logic [7:0] bcd_inc(
    input logic [7:0] v,
    input logic [7:0] lim
  );
    if (v >= lim) return 8'h00;
    if (v[3:0] >= 4'd9) return {v[7:4] + 4'd1, 4'h0};
    return v + 8'd1;
  endfunction

  function automatic logic [7:0] clamp(
    input logic [7:0] d,
    input logic [7:0] lim
  );
    logic [7:0] v;
    v = {1'b0, d[6:0]};
    return (v > lim) ? 8'h00 : v;
  endfunction

  logic       s_ad_q, s_cs_q, s_rd_q, s_wr_q;
  logic       p_ad_q, p_wr_q;
  logic [7:0] s_data_q;

  state_t     state_q, state_d;
  logic [2:0] cnt_q, cnt_d;
  logic       oe_d, err_d;
  logic       addr_we, reg_we;
  logic [7:0] addr_q;

  logic [7:0] sec_q, sec_d;
  logic [7:0] min_q, min_d;
  logic [7:0] hr_q, hr_d;
  logic       run_q, run_d;
  logic [PW-1:0] pre_q, pre_d;
  logic       wrap;

  logic [7:0] ram_q [0:11];
  logic [3:0] ram_idx;
  logic       ram_sel;
  logic [7:0] rdata;

  logic [7:0] dout_q;
  logic       oe_q, tick_q, err_q;

  logic wr_rise, proto_err;

  assign wr_rise = ~p_wr_q & s_wr_q;
  assign proto_err = (~s_rd_q & ~s_wr_q)
                   | (~s_rd_q & ~s_ad_q)
                   | (~s_wr_q & (s_ad_q ^ p_ad_q));

  // Single sample stage plus previous copy for edge detection
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      s_ad_q   <= 1'b0;
      s_cs_q   <= 1'b1;
      s_rd_q   <= 1'b1;
      s_wr_q   <= 1'b1;
      s_data_q <= 8'h00;
      p_ad_q   <= 1'b0;
      p_wr_q   <= 1'b1;
    end else begin
      s_ad_q   <= AD;
      s_cs_q   <= CS;
      s_rd_q   <= RD;
      s_wr_q   <= WR;
      s_data_q <= data_in;
      p_ad_q   <= s_ad_q;
      p_wr_q   <= s_wr_q;
    end
  end

  // Bus FSM state and read latency counter
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      cnt_q   <= 3'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next state, strobes and error pulse
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    err_d   = 1'b0;
    addr_we = 1'b0;
    reg_we  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (!s_cs_q) state_d = SEL;
      end
      SEL: begin
        if (s_cs_q) begin
          state_d = IDLE;
        end else if (proto_err) begin
          state_d = ERR;
          err_d   = 1'b1;
        end else begin
          addr_we = wr_rise & ~s_ad_q;
          reg_we  = wr_rise & s_ad_q;
          if (!s_rd_q) begin
            state_d = READ;
            cnt_d   = 3'd1;
          end
        end
      end
      READ: begin
        if (s_cs_q) begin
          state_d = IDLE;
        end else if (proto_err) begin
          state_d = ERR;
          err_d   = 1'b1;
        end else if (s_rd_q) begin
          state_d = SEL;
        end else if (cnt_q < LAT) begin
          cnt_d = cnt_q + 3'd1;
        end
      end
      ERR: begin
        if (s_cs_q) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    oe_d = (state_d == READ) && (cnt_d >= LAT);
  end

  // Address latch
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) addr_q <= 8'h00;
    else if (addr_we) addr_q <= s_data_q;
  end

  // Time base: prescaler, carry chain, then bus write overrides
  always_comb begin
    wrap  = run_q && (pre_q == TOP);
    sec_d = sec_q;
    min_d = min_q;
    hr_d  = hr_q;
    run_d = run_q;
    pre_d = pre_q;
    if (run_q) pre_d = wrap ? '0 : pre_q + PW'(1);
    if (wrap) begin
      sec_d = bcd_inc(sec_q, 8'h59);
      if (sec_q >= 8'h59) begin
        min_d = bcd_inc(min_q, 8'h59);
        if (min_q >= 8'h59) hr_d = bcd_inc(hr_q, 8'h23);
      end
    end
    if (reg_we) begin
      unique case (1'b1)
        (addr_q == 8'h00): sec_d = clamp(s_data_q, 8'h59);
        (addr_q == 8'h01): min_d = clamp(s_data_q, 8'h59);
        (addr_q == 8'h02): hr_d  = clamp(s_data_q, 8'h23);
        (addr_q == 8'h03): begin
          run_d = s_data_q[0];
          pre_d = '0;
        end
        default: ;
      endcase
    end
  end

  // Time and control registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sec_q <= 8'h00;
      min_q <= 8'h00;
      hr_q  <= 8'h00;
      run_q <= 1'b1;
      pre_q <= '0;
    end else begin
      sec_q <= sec_d;
      min_q <= min_d;
      hr_q  <= hr_d;
      run_q <= run_d;
      pre_q <= pre_d;
    end
  end

  assign ram_sel = (addr_q >= 8'h04) && (addr_q <= 8'h0F);
  assign ram_idx = addr_q[3:0] - 4'd4;

  // Scratch RAM
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < 12; i++) ram_q[i] <= 8'h00;
    end else if (reg_we && ram_sel) begin
      ram_q[ram_idx] <= s_data_q;
    end
  end

  // Read mux
  always_comb begin
    rdata = 8'h00;
    unique case (1'b1)
      (addr_q == 8'h00): rdata = sec_q;
      (addr_q == 8'h01): rdata = min_q;
      (addr_q == 8'h02): rdata = hr_q;
      (addr_q == 8'h03): rdata = {7'h00, run_q};
      ram_sel:           rdata = ram_q[ram_idx];
      default:           rdata = 8'h00;
    endcase
  end

  // Registered outputs
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      dout_q <= 8'h00;
      oe_q   <= 1'b0;
      tick_q <= 1'b0;
      err_q  <= 1'b0;
    end else begin
      dout_q <= oe_d ? rdata : 8'h00;
      oe_q   <= oe_d;
      tick_q <= wrap;
      err_q  <= err_d;
    end
  end

  assign data_out = dout_q;
  assign data_oe  = oe_q;
  assign tick     = tick_q;
  assign bus_err  = err_q;

endmodule

// File: tb/tb_rtc_bus_responder.sv
// Directed bench for rtc_bus_responder.
// Small prescaler so second ticks fit in short runs.
module tb_rtc_bus_responder;

  localparam int TD = 16;
  localparam int RL = 2;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       AD, CS, RD, WR;
  logic [7:0] din;
  logic [7:0] dout;
  logic       oe, tick, berr;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  rtc_bus_responder #(
    .TICK_DIV(TD),
    .READ_LAT(RL)
  ) dut (
    .clk     (clk),
    .reset   (rst_n),
    .AD      (AD),
    .CS      (CS),
    .RD      (RD),
    .WR      (WR),
    .data_in (din),
    .data_out(dout),
    .data_oe (oe),
    .tick    (tick),
    .bus_err (berr)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic clk1();
    @(posedge clk);
    #1;
  endtask

  task automatic bus_wr(input logic ad, input logic [7:0] v);
    AD = ad;
    din = v;
    clk1();
    WR = 1'b0;
    clk1();
    WR = 1'b1;
    clk1();
    clk1();
  endtask

  task automatic sel();
    CS = 1'b0;
    repeat (3) clk1();
  endtask

  task automatic desel();
    CS = 1'b1;
    RD = 1'b1;
    WR = 1'b1;
    AD = 1'b0;
    repeat (3) clk1();
  endtask

  task automatic bus_rd(input logic [7:0] a,
                        output logic [7:0] v,
                        output int lat);
    bus_wr(1'b0, a);
    AD = 1'b1;
    clk1();
    RD = 1'b0;
    lat = 0;
    while (oe !== 1'b1 && lat < 20) begin
      clk1();
      lat++;
    end
    v = dout;
    RD = 1'b1;
    repeat (3) clk1();
  endtask

  task automatic test_reset();
    logic [7:0] v;
    int lat;
    rst_n = 1'b0;
    AD = 1'b0; CS = 1'b1; RD = 1'b1; WR = 1'b1;
    din = 8'h00;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    clk1();
    checks++;
    if (dout !== 8'h00) begin
      failures++;
      $display("FAIL rst_dout got=%h exp=00", dout);
    end
    checks++;
    if (oe !== 1'b0) begin
      failures++;
      $display("FAIL rst_oe got=%b exp=0", oe);
    end
    checks++;
    if (tick !== 1'b0) begin
      failures++;
      $display("FAIL rst_tick got=%b exp=0", tick);
    end
    checks++;
    if (berr !== 1'b0) begin
      failures++;
      $display("FAIL rst_berr got=%b exp=0", berr);
    end
    sel();
    bus_rd(8'h03, v, lat);
    checks++;
    if (v !== 8'h01) begin
      failures++;
      $display("FAIL rst_ctrl got=%h exp=01", v);
    end
    desel();
  endtask

  task automatic test_write_read();
    logic [7:0] v;
    int lat;
    sel();
    bus_wr(1'b0, 8'h05);
    bus_wr(1'b1, 8'hA5);
    bus_rd(8'h05, v, lat);
    checks++;
    if (v !== 8'hA5) begin
      failures++;
      $display("FAIL rd_05 got=%h exp=a5", v);
    end
    checks++;
    if (lat !== RL + 1) begin
      failures++;
      $display("FAIL rd_lat got=%0d exp=%0d", lat, RL + 1);
    end
    bus_wr(1'b0, 8'h0F);
    bus_wr(1'b1, 8'h3C);
    bus_rd(8'h0F, v, lat);
    checks++;
    if (v !== 8'h3C) begin
      failures++;
      $display("FAIL rd_0f got=%h exp=3c", v);
    end
    bus_rd(8'h04, v, lat);
    checks++;
    if (v !== 8'h00) begin
      failures++;
      $display("FAIL rd_04 got=%h exp=00", v);
    end
    bus_wr(1'b0, 8'h10);
    bus_wr(1'b1, 8'h77);
    bus_rd(8'h10, v, lat);
    checks++;
    if (v !== 8'h00) begin
      failures++;
      $display("FAIL rd_10 got=%h exp=00", v);
    end
    bus_wr(1'b0, 8'h02);
    bus_wr(1'b1, 8'h35);
    bus_rd(8'h02, v, lat);
    checks++;
    if (v !== 8'h00) begin
      failures++;
      $display("FAIL hr_bad got=%h exp=00", v);
    end
    bus_wr(1'b1, 8'h1A);
    bus_rd(8'h02, v, lat);
    checks++;
    if (v !== 8'h1A) begin
      failures++;
      $display("FAIL hr_1a got=%h exp=1a", v);
    end
    bus_wr(1'b0, 8'h03);
    bus_wr(1'b1, 8'hFF);
    bus_rd(8'h03, v, lat);
    checks++;
    if (v !== 8'h01) begin
      failures++;
      $display("FAIL ctrl_ff got=%h exp=01", v);
    end
    desel();
  endtask

  task automatic test_rollover();
    logic [7:0] v;
    int lat, e, early;
    sel();
    bus_wr(1'b0, 8'h03);
    bus_wr(1'b1, 8'h00);
    bus_wr(1'b0, 8'h00);
    bus_wr(1'b1, 8'h59);
    bus_wr(1'b0, 8'h01);
    bus_wr(1'b1, 8'h59);
    bus_wr(1'b0, 8'h02);
    bus_wr(1'b1, 8'h23);
    bus_wr(1'b0, 8'h03);
    AD = 1'b1;
    din = 8'h01;
    clk1();
    WR = 1'b0;
    clk1();
    WR = 1'b1;
    e = cyc + 2;
    early = 0;
    while (cyc < e + TD - 1) begin
      clk1();
      if (tick === 1'b1) early++;
    end
    checks++;
    if (early !== 0) begin
      failures++;
      $display("FAIL roll_early got=%0d exp=0", early);
    end
    clk1();
    checks++;
    if (tick !== 1'b1) begin
      failures++;
      $display("FAIL roll_tick got=%b exp=1", tick);
    end
    din = 8'h00;
    WR = 1'b0;
    clk1();
    WR = 1'b1;
    clk1();
    clk1();
    bus_rd(8'h00, v, lat);
    checks++;
    if (v !== 8'h00) begin
      failures++;
      $display("FAIL roll_sec got=%h exp=00", v);
    end
    bus_rd(8'h01, v, lat);
    checks++;
    if (v !== 8'h00) begin
      failures++;
      $display("FAIL roll_min got=%h exp=00", v);
    end
    bus_rd(8'h02, v, lat);
    checks++;
    if (v !== 8'h00) begin
      failures++;
      $display("FAIL roll_hr got=%h exp=00", v);
    end
    desel();
  endtask

  task automatic test_run_stop();
    logic [7:0] v;
    int lat, ticks;
    sel();
    bus_wr(1'b0, 8'h03);
    bus_wr(1'b1, 8'h00);
    bus_wr(1'b0, 8'h00);
    bus_wr(1'b1, 8'h42);
    ticks = 0;
    repeat (20) begin
      clk1();
      if (tick === 1'b1) ticks++;
    end
    bus_rd(8'h00, v, lat);
    checks++;
    if (v !== 8'h42) begin
      failures++;
      $display("FAIL stop_sec got=%h exp=42", v);
    end
    checks++;
    if (ticks !== 0) begin
      failures++;
      $display("FAIL stop_tick got=%0d exp=0", ticks);
    end
    bus_rd(8'h03, v, lat);
    checks++;
    if (v !== 8'h00) begin
      failures++;
      $display("FAIL stop_ctrl got=%h exp=00", v);
    end
    desel();
  endtask

  task automatic test_simultaneous();
    logic [7:0] v;
    int lat, e;
    sel();
    bus_wr(1'b0, 8'h00);
    bus_wr(1'b1, 8'h59);
    bus_wr(1'b0, 8'h01);
    bus_wr(1'b1, 8'h10);
    bus_wr(1'b0, 8'h03);
    AD = 1'b1;
    din = 8'h01;
    clk1();
    WR = 1'b0;
    clk1();
    WR = 1'b1;
    e = cyc + 2;
    clk1();
    clk1();
    bus_wr(1'b0, 8'h00);
    AD = 1'b1;
    din = 8'h30;
    clk1();
    WR = 1'b0;
    while (cyc < e + TD - 2) clk1();
    WR = 1'b1;
    clk1();
    clk1();
    checks++;
    if (tick !== 1'b1) begin
      failures++;
      $display("FAIL sim_tick got=%b exp=1", tick);
    end
    bus_wr(1'b0, 8'h03);
    bus_wr(1'b1, 8'h00);
    bus_rd(8'h00, v, lat);
    checks++;
    if (v !== 8'h30) begin
      failures++;
      $display("FAIL sim_sec got=%h exp=30", v);
    end
    bus_rd(8'h01, v, lat);
    checks++;
    if (v !== 8'h11) begin
      failures++;
      $display("FAIL sim_min got=%h exp=11", v);
    end
    desel();
  endtask

  task automatic test_error();
    logic [7:0] v;
    int lat, errs, oes;
    sel();
    bus_wr(1'b0, 8'h05);
    bus_wr(1'b1, 8'h5A);
    AD = 1'b1;
    din = 8'hEE;
    clk1();
    RD = 1'b0;
    WR = 1'b0;
    errs = 0;
    oes = 0;
    repeat (6) begin
      clk1();
      if (berr === 1'b1) errs++;
      if (oe === 1'b1) oes++;
    end
    RD = 1'b1;
    WR = 1'b1;
    repeat (3) begin
      clk1();
      if (berr === 1'b1) errs++;
      if (oe === 1'b1) oes++;
    end
    checks++;
    if (errs !== 1) begin
      failures++;
      $display("FAIL err_pulse got=%0d exp=1", errs);
    end
    checks++;
    if (oes !== 0) begin
      failures++;
      $display("FAIL err_oe got=%0d exp=0", oes);
    end
    desel();
    sel();
    bus_rd(8'h05, v, lat);
    checks++;
    if (v !== 8'h5A) begin
      failures++;
      $display("FAIL err_reg got=%h exp=5a", v);
    end
    AD = 1'b0;
    clk1();
    RD = 1'b0;
    errs = 0;
    repeat (5) begin
      clk1();
      if (berr === 1'b1) errs++;
    end
    checks++;
    if (errs !== 1) begin
      failures++;
      $display("FAIL err_rd_ad0 got=%0d exp=1", errs);
    end
    desel();
  endtask

  task automatic test_reset_midread();
    logic [7:0] v;
    int lat;
    sel();
    bus_wr(1'b0, 8'h05);
    AD = 1'b1;
    clk1();
    RD = 1'b0;
    repeat (RL + 1) clk1();
    checks++;
    if (oe !== 1'b1) begin
      failures++;
      $display("FAIL mid_oe_pre got=%b exp=1", oe);
    end
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (oe !== 1'b0) begin
      failures++;
      $display("FAIL mid_oe_rst got=%b exp=0", oe);
    end
    checks++;
    if (dout !== 8'h00) begin
      failures++;
      $display("FAIL mid_dout got=%h exp=00", dout);
    end
    CS = 1'b1;
    RD = 1'b1;
    WR = 1'b1;
    AD = 1'b0;
    clk1();
    rst_n = 1'b1;
    repeat (3) clk1();
    sel();
    bus_rd(8'h05, v, lat);
    checks++;
    if (v !== 8'h00) begin
      failures++;
      $display("FAIL mid_ram got=%h exp=00", v);
    end
    bus_rd(8'h03, v, lat);
    checks++;
    if (v !== 8'h01) begin
      failures++;
      $display("FAIL mid_ctrl got=%h exp=01", v);
    end
    desel();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog timeout at cyc=%0d", cyc);
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_write_read();
    test_rollover();
    test_run_stop();
    test_simultaneous();
    test_error();
    test_reset_midread();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
